// File: rtl/snn_img_loader_pkg.sv
// Shared types and sizing helpers for the SNN image loader.
// Optional build macro used by the loader: SNN_LOADER_TIMEOUT_EN.
package snn_pkg;

    typedef enum logic [2:0] {
        S_RECV   = 3'd0,
        S_UNPACK = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_SEND   = 3'd4,
        S_TXWAIT = 3'd5
    } state_e;

    localparam int TX_W = 8;

    function automatic int ppb(input int pix_bits);
        return 8 / pix_bits;
    endfunction

    function automatic int nbytes(input int img_pixels, input int pix_bits);
        return (img_pixels + ppb(pix_bits) - 1) / ppb(pix_bits);
    endfunction

    function automatic int tx_pad_w(input int res_w);
        return TX_W - res_w;
    endfunction

endpackage

// File: rtl/snn_img_loader_if.sv
// Bus bundle between the image loader and its UART, pixel RAM and SNN core.
interface snn_img_loader_if #(
    parameter int ADDR_W   = 10,
    parameter int PIX_BITS = 1,
    parameter int RES_W    = 4
);
    logic                rx_rdy;
    logic [7:0]          rx_data;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [PIX_BITS-1:0] ram_wdata;
    logic                core_start;
    logic                core_done;
    logic [RES_W-1:0]    core_result;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_rdy;
    logic                busy;
    logic [RES_W-1:0]    result;
    logic                err_ovf;
    logic                abort;

    modport master (
        input  rx_rdy, rx_data, core_done, core_result, tx_rdy,
        output ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data,
               busy, result, err_ovf, abort
    );

    modport slave (
        output rx_rdy, rx_data, core_done, core_result, tx_rdy,
        input  ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data,
               busy, result, err_ovf, abort
    );
endinterface

// File: rtl/snn_img_loader_unpacker.sv
// Byte shift register that hands out pixels LSB-first, PIX_BITS at a time.
module snn_unpacker
    import snn_pkg::*;
#(
    parameter int PIX_BITS = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [7:0]          i_data,
    input  logic                i_shift,
    output logic [PIX_BITS-1:0] o_pix,
    output logic                o_last
);
    localparam int PPB = ppb(PIX_BITS);

    logic [7:0] r_shreg;
    logic [3:0] r_sub;

    // Load a fresh byte or step to the next pixel within it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg <= 8'd0;
            r_sub   <= 4'd0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_sub   <= 4'd0;
        end else if (i_shift) begin
            r_shreg <= r_shreg >> PIX_BITS;
            r_sub   <= r_sub + 4'd1;
        end
    end

    assign o_pix  = r_shreg[PIX_BITS-1:0];
    assign o_last = (r_sub == 4'(PPB - 1));
endmodule

// File: rtl/snn_img_loader.sv
// UART-to-core sequencer: unpack image bytes into RAM, run the core, send the result.
// Define SNN_LOADER_TIMEOUT_EN to abort a partial image after TIMEOUT_CYC idle cycles.
module snn_img_loader
    import snn_pkg::*;
#(
    parameter int IMG_PIXELS  = 784,
    parameter int PIX_BITS    = 1,
    parameter int ADDR_W      = 10,
    parameter int RES_W       = 4,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    snn_img_loader_if.master   if_bus
);
    localparam int NBYTES = nbytes(IMG_PIXELS, PIX_BITS);
    localparam int BC_W   = $clog2(NBYTES + 1);
    localparam int PAD_W  = tx_pad_w(RES_W);

    state_e              r_state;
    state_e              w_next;
    logic [ADDR_W-1:0]   r_pix_cnt;
    logic [BC_W-1:0]     r_byte_cnt;
    logic [RES_W-1:0]    r_result;
    logic                r_err_ovf;
    logic                r_tx_hold;
    logic                w_load;
    logic                w_last_sub;
    logic                w_last_pix;
    logic                w_timeout;
    logic [PIX_BITS-1:0] w_pix;

    assign w_load     = (r_state == S_RECV) && if_bus.rx_rdy;
    assign w_last_pix = (r_pix_cnt == ADDR_W'(IMG_PIXELS - 1));

    snn_unpacker #(.PIX_BITS(PIX_BITS)) u_unpacker (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_data  (if_bus.rx_data),
        .i_shift (r_state == S_UNPACK),
        .o_pix   (w_pix),
        .o_last  (w_last_sub)
    );

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RECV:   if (w_load) w_next = S_UNPACK; else w_next = S_RECV;
            S_UNPACK: begin
                if (w_last_pix)      w_next = S_START;
                else if (w_last_sub) w_next = S_RECV;
                else                 w_next = S_UNPACK;
            end
            S_START:  w_next = S_WAIT;
            S_WAIT:   if (if_bus.core_done) w_next = S_SEND; else w_next = S_WAIT;
            S_SEND:   if (if_bus.tx_rdy) w_next = S_TXWAIT; else w_next = S_SEND;
            // r_tx_hold skips the cycle in which the transmitter may still report idle.
            S_TXWAIT: if (!r_tx_hold && if_bus.tx_rdy) w_next = S_RECV; else w_next = S_TXWAIT;
            default:  w_next = S_RECV;
        endcase
    end

    // State, counters, held result and sticky overrun flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_RECV;
            r_pix_cnt  <= '0;
            r_byte_cnt <= '0;
            r_result   <= '0;
            r_err_ovf  <= 1'b0;
            r_tx_hold  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_UNPACK) begin
                r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + ADDR_W'(1);
            end else if (r_state == S_START || w_timeout) begin
                r_pix_cnt <= '0;
            end
            if (w_load) begin
                r_byte_cnt <= r_byte_cnt + BC_W'(1);
            end else if (w_timeout || (r_state == S_TXWAIT && w_next == S_RECV)) begin
                r_byte_cnt <= '0;
            end
            if (r_state == S_WAIT && if_bus.core_done) begin
                r_result <= if_bus.core_result;
            end
            if (if_bus.rx_rdy && r_state != S_RECV) begin
                r_err_ovf <= 1'b1;
            end
            r_tx_hold <= (r_state == S_SEND) && if_bus.tx_rdy;
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == S_RECV) && (r_byte_cnt != '0) && !if_bus.rx_rdy
                       && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Idle timer, only running while a partial image sits in RECV.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (r_state != S_RECV || r_byte_cnt == '0 || if_bus.rx_rdy || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    // TIMEOUT_CYC has no effect here; the guard only keeps the parameter referenced.
    if (TIMEOUT_CYC >= 1) begin : g_no_timeout
        assign w_timeout = 1'b0;
    end else begin : g_no_timeout_alt
        assign w_timeout = 1'b0;
    end
`endif

    if (PAD_W > 0) begin : g_tx_pad
        assign if_bus.tx_data = {{PAD_W{1'b0}}, r_result};
    end else begin : g_tx_nopad
        assign if_bus.tx_data = r_result;
    end

    assign if_bus.ram_we     = (r_state == S_UNPACK);
    assign if_bus.ram_addr   = r_pix_cnt;
    assign if_bus.ram_wdata  = w_pix;
    assign if_bus.core_start = (r_state == S_START);
    assign if_bus.tx_start   = (r_state == S_SEND) && if_bus.tx_rdy;
    assign if_bus.busy       = !((r_state == S_RECV) && (r_byte_cnt == '0));
    assign if_bus.result     = r_result;
    assign if_bus.err_ovf    = r_err_ovf;
    assign if_bus.abort      = w_timeout;
endmodule

// File: tb/tb_snn_img_loader.sv
// Bench for snn_img_loader: three parameter sets checked against a pixel-level model.
module tb_snn_img_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    snn_img_loader_if #(.ADDR_W(4),  .PIX_BITS(1), .RES_W(4)) if_a ();
    snn_img_loader_if #(.ADDR_W(3),  .PIX_BITS(2), .RES_W(4)) if_b ();
    snn_img_loader_if #(.ADDR_W(10), .PIX_BITS(1), .RES_W(4)) if_c ();

    snn_img_loader #(.IMG_PIXELS(10), .PIX_BITS(1), .ADDR_W(4), .RES_W(4), .TIMEOUT_CYC(100))
        u_a (.i_clk(clk), .i_rst(rst), .if_bus(if_a));
    snn_img_loader #(.IMG_PIXELS(6), .PIX_BITS(2), .ADDR_W(3), .RES_W(4), .TIMEOUT_CYC(100))
        u_b (.i_clk(clk), .i_rst(rst), .if_bus(if_b));
    snn_img_loader u_c (.i_clk(clk), .i_rst(rst), .if_bus(if_c));

    logic [7:0] bytes_a [2];
    logic [7:0] bytes_b [2];
    logic [7:0] bytes_c [98];
    int cap_a [10];
    int cap_b [6];
    int lit_a [10] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    int lit_b [6]  = '{0, 1, 2, 3, 3, 2};
    int exp_a = 0, exp_b = 0, exp_c = 0;
    bit due_a = 1'b0, due_b = 1'b0, due_c = 1'b0;
    int we_a = 0, we_b = 0, we_c = 0;
    int starts_a = 0, starts_b = 0, starts_c = 0;
    int tx_c = 0;
    int exp_res_c = 0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Pixel p of an image lives in byte p/PPB at bit offset (p%PPB)*PIX_BITS.
    function automatic int model_pix(input logic [7:0] b, input int sub, input int pb);
        int v;
        v = int'(b);
        return (v >> (sub * pb)) & ((1 << pb) - 1);
    endfunction

    task automatic send(input int inst, input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        case (inst)
            0:       begin if_a.rx_data = b; if_a.rx_rdy = 1'b1; end
            1:       begin if_b.rx_data = b; if_b.rx_rdy = 1'b1; end
            default: begin if_c.rx_data = b; if_c.rx_rdy = 1'b1; end
        endcase
        @(posedge clk); #1;
        if_a.rx_rdy = 1'b0;
        if_b.rx_rdy = 1'b0;
        if_c.rx_rdy = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // Instance A compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.core_start || due_a) begin
                check("a_core_start", int'(if_a.core_start), int'(due_a));
                if (due_a) begin due_a = 1'b0; exp_a = 0; starts_a++; end
            end
            if (if_a.ram_we) begin
                we_a++;
                if (int'(if_a.ram_addr) < 10) cap_a[if_a.ram_addr] = int'(if_a.ram_wdata);
                if (exp_a < 10) begin
                    check("a_addr", int'(if_a.ram_addr), exp_a);
                    check("a_data", int'(if_a.ram_wdata), model_pix(bytes_a[exp_a / 8], exp_a % 8, 1));
                    exp_a++;
                    if (exp_a == 10) due_a = 1'b1;
                end else begin
                    check("a_unexpected_write_addr", int'(if_a.ram_addr), -1);
                end
            end
`ifndef SNN_LOADER_TIMEOUT_EN
            check("a_abort_tied", int'(if_a.abort), 0);
`endif
        end
    end

    // Instance B compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_b.core_start || due_b) begin
                check("b_core_start", int'(if_b.core_start), int'(due_b));
                if (due_b) begin due_b = 1'b0; exp_b = 0; starts_b++; end
            end
            if (if_b.ram_we) begin
                we_b++;
                if (int'(if_b.ram_addr) < 6) cap_b[if_b.ram_addr] = int'(if_b.ram_wdata);
                if (exp_b < 6) begin
                    check("b_addr", int'(if_b.ram_addr), exp_b);
                    check("b_data", int'(if_b.ram_wdata), model_pix(bytes_b[exp_b / 4], exp_b % 4, 2));
                    exp_b++;
                    if (exp_b == 6) due_b = 1'b1;
                end else begin
                    check("b_unexpected_write_addr", int'(if_b.ram_addr), -1);
                end
            end
        end
    end

    // Instance C compare (default parameters).
    always @(negedge clk) begin
        if (!rst) begin
            if (if_c.core_start || due_c) begin
                check("c_core_start", int'(if_c.core_start), int'(due_c));
                if (due_c) begin due_c = 1'b0; exp_c = 0; starts_c++; end
            end
            if (if_c.ram_we) begin
                we_c++;
                if (exp_c < 784) begin
                    check("c_addr", int'(if_c.ram_addr), exp_c);
                    check("c_data", int'(if_c.ram_wdata), model_pix(bytes_c[exp_c / 8], exp_c % 8, 1));
                    exp_c++;
                    if (exp_c == 784) due_c = 1'b1;
                end else begin
                    check("c_unexpected_write_addr", int'(if_c.ram_addr), -1);
                end
            end
            if (if_c.tx_start) begin
                tx_c++;
                check("c_tx_data", int'(if_c.tx_data), exp_res_c);
            end
            check("c_abort_idle", int'(if_c.abort), 0);
        end
    end

    task automatic check_c_zero(input string tag);
        check({tag, "_ram_we"},     int'(if_c.ram_we), 0);
        check({tag, "_core_start"}, int'(if_c.core_start), 0);
        check({tag, "_tx_start"},   int'(if_c.tx_start), 0);
        check({tag, "_tx_data"},    int'(if_c.tx_data), 0);
        check({tag, "_busy"},       int'(if_c.busy), 0);
        check({tag, "_result"},     int'(if_c.result), 0);
        check({tag, "_err_ovf"},    int'(if_c.err_ovf), 0);
        check({tag, "_abort"},      int'(if_c.abort), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int w0;
        rst = 1'b1;
        if_a.rx_rdy = 1'b0; if_a.rx_data = 8'd0; if_a.core_done = 1'b0; if_a.core_result = 4'd0; if_a.tx_rdy = 1'b1;
        if_b.rx_rdy = 1'b0; if_b.rx_data = 8'd0; if_b.core_done = 1'b0; if_b.core_result = 4'd0; if_b.tx_rdy = 1'b1;
        if_c.rx_rdy = 1'b0; if_c.rx_data = 8'd0; if_c.core_done = 1'b0; if_c.core_result = 4'd0; if_c.tx_rdy = 1'b1;
        bytes_a[0] = 8'hA5; bytes_a[1] = 8'h03;
        bytes_b[0] = 8'hE4; bytes_b[1] = 8'h0B;
        for (int i = 0; i < 98; i++) bytes_c[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 10; i++) cap_a[i] = -1;
        for (int i = 0; i < 6; i++) cap_b[i] = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_c_zero("reset");
        check("reset_a_busy", int'(if_a.busy), 0);
        check("reset_b_busy", int'(if_b.busy), 0);
        rst = 1'b0;

`ifdef SNN_LOADER_TIMEOUT_EN
        // One byte then silence: expect an abort after roughly TIMEOUT_CYC idle cycles.
        send(0, 8'hA5, 0);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (if_a.abort) break;
        end
        check("a_abort_latency_ok", int'(n >= 100 && n <= 130), 1);
        @(negedge clk);
        check("a_abort_one_cycle", int'(if_a.abort), 0);
        check("a_busy_after_abort", int'(if_a.busy), 0);
        check("a_no_start_on_abort", starts_a, 0);
        exp_a = 0;
        for (int i = 0; i < 10; i++) cap_a[i] = -1;
`endif
        we_a = 0;
        send(0, 8'hA5, 10);
        send(0, 8'h03, 10);
        repeat (4) @(negedge clk);
        check("a_we_count", we_a, 10);
        check("a_start_count", starts_a, 1);
        for (int i = 0; i < 10; i++) check("a_ram_literal", cap_a[i], lit_a[i]);

        send(1, 8'hE4, 10);
        send(1, 8'h0B, 10);
        repeat (4) @(negedge clk);
        check("b_we_count", we_b, 6);
        check("b_start_count", starts_b, 1);
        for (int i = 0; i < 6; i++) check("b_ram_literal", cap_b[i], lit_b[i]);

        for (int i = 0; i < 98; i++) send(2, bytes_c[i], 10);
        repeat (2) @(negedge clk);
        check("c_we_count", we_c, 784);
        check("c_start_count", starts_c, 1);
        check("c_busy_in_wait", int'(if_c.busy), 1);

        w0 = we_c;
        send(2, 8'hFF, 3);
        @(negedge clk);
        check("c_err_ovf_set", int'(if_c.err_ovf), 1);
        check("c_ovf_no_write", we_c, w0);

        exp_res_c = 7;
        @(posedge clk); #1;
        if_c.core_result = 4'd7; if_c.core_done = 1'b1;
        @(posedge clk); #1;
        if_c.core_done = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (if_c.tx_start) break;
        end
        check("c_tx_start_seen", int'(n < 10), 1);
        @(posedge clk); #1;
        if_c.tx_rdy = 1'b0;
        @(negedge clk);
        check("c_result_latched", int'(if_c.result), 7);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("c_busy_txwait", int'(if_c.busy), 1);
        @(posedge clk); #1;
        if_c.tx_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("c_busy_after_tx", int'(if_c.busy), 0);
        check("c_tx_count", tx_c, 1);
        check("c_err_ovf_sticky", int'(if_c.err_ovf), 1);
        check("c_result_held", int'(if_c.result), 7);
        check("c_tx_data_held", int'(if_c.tx_data), 7);

        w0 = we_c;
        for (int i = 0; i < 40; i++) send(2, bytes_c[i], 10);
        check("c_partial_writes", we_c - w0, 320);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_c = 0;
        due_c = 1'b0;
        exp_res_c = 0;
        @(posedge clk);
        @(negedge clk);
        check_c_zero("midrst");
        rst = 1'b0;

        w0 = we_c;
        for (int i = 0; i < 98; i++) send(2, bytes_c[i], 10);
        repeat (2) @(negedge clk);
        check("c_second_we_count", we_c - w0, 784);
        check("c_second_start_count", starts_c, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
